// File: rtl/flop_reader.sv
// Captures a parallel word from an upstream register on request and streams it
// out one bit per accepted beat under a valid/ready handshake, then pulses done.
module flop_reader #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             rd_req,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             done_reg;
    logic             out_bit;

    // The output end of the shift register depends on bit order; every
    // accepted beat moves the word one place toward that end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            assign out_bit    = shift_reg[WIDTH-1];
        end else begin : g_lsb_first
            assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            assign out_bit    = shift_reg[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rset_n) begin
        if (!rset_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (rd_req) begin
                        shift_reg <= d;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                        busy_reg  <= 1'b1;
                        valid_reg <= 1'b1;
                        last_reg  <= (LAST_IDX == '0);
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        shift_reg <= shift_next;
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg  <= cnt_reg + CNT_ONE;
                            last_reg <= ((cnt_reg + CNT_ONE) == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign ser_valid = valid_reg;
    assign ser_last  = last_reg;
    assign done      = done_reg;
    assign ser_out   = out_bit;

endmodule

// File: tb/tb_flop_reader.sv
// Bench for flop_reader: an LSB-first and an MSB-first instance share stimulus
// and are checked beat by beat against the bit index of the captured word.
module tb_flop_reader;

    localparam int W      = 32;
    localparam int PERIOD = 10;

    logic         clk       = 1'b0;
    logic         rset_n    = 1'b1;
    logic         rd_req    = 1'b0;
    logic         ser_ready = 1'b0;
    logic [W-1:0] d         = '0;

    logic busy0, ser_out0, ser_valid0, ser_last0, done0;
    logic busy1, ser_out1, ser_valid1, ser_last1, done1;

    int  n_checks = 0;
    int  n_fail   = 0;
    time cap_time;
    time idle_time;

    always #(PERIOD/2) clk = ~clk;

    flop_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rset_n(rset_n), .d(d), .rd_req(rd_req),
        .busy(busy0), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .ser_ready(ser_ready), .ser_last(ser_last0), .done(done0)
    );

    flop_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rset_n(rset_n), .d(d), .rd_req(rd_req),
        .busy(busy1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .ser_ready(ser_ready), .ser_last(ser_last1), .done(done1)
    );

    // mode: 0 = ready always, 1 = ready toggles 1,0,1,0..., 2 = random ready.
    // disturb: overwrite d and hold rd_req during the word and through DONE.
    task automatic send_word(input logic [W-1:0] w, input int mode,
                             input bit hold_req, input bit disturb);
        int k;
        int cyc;
        bit r;
        d      = w;
        rd_req = 1'b1;
        @(posedge clk);
        cap_time = $time;
        @(negedge clk);
        if (disturb) d = '1;
        if (!hold_req && !disturb) rd_req = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < W && cyc < 4000) begin
            n_checks++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1 || ser_valid0 !== 1'b1 ||
                ser_valid1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_flags beat %0d: busy=%b/%b valid=%b/%b done=%b/%b, required 1/1 1/1 0/0",
                         k, busy0, busy1, ser_valid0, ser_valid1, done0, done1);
            end
            n_checks++;
            if (ser_out0 !== w[k]) begin
                n_fail++;
                $display("FAIL lsb_bit beat %0d word %h: got %b, required %b", k, w, ser_out0, w[k]);
            end
            n_checks++;
            if (ser_out1 !== w[W-1-k]) begin
                n_fail++;
                $display("FAIL msb_bit beat %0d word %h: got %b, required %b", k, w, ser_out1, w[W-1-k]);
            end
            n_checks++;
            if (ser_last0 !== (k == W-1) || ser_last1 !== (k == W-1)) begin
                n_fail++;
                $display("FAIL ser_last beat %0d: got %b/%b, required %b", k, ser_last0, ser_last1, (k == W-1));
            end
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc % 2 == 0);
            else                r = 1'($urandom_range(0, 1));
            ser_ready = r;
            @(posedge clk);
            if (r) k++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (k != W) begin
            n_fail++;
            $display("FAIL beat_budget: got %0d beats, required %0d", k, W);
        end
        n_checks++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || busy0 !== 1'b0 || busy1 !== 1'b0 ||
            ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0 || ser_last0 !== 1'b0 || ser_last1 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle word %h: done=%b/%b busy=%b/%b valid=%b/%b last=%b/%b, required done=1 others 0",
                     w, done0, done1, busy0, busy1, ser_valid0, ser_valid1, ser_last0, ser_last1);
        end
        @(negedge clk);
        idle_time = $time;
        n_checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0 ||
            ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done word %h: done=%b/%b busy=%b/%b valid=%b/%b, required all 0",
                     w, done0, done1, busy0, busy1, ser_valid0, ser_valid1);
        end
        if (disturb) rd_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 rset_n = 1'b0;
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || ser_out0 !== 1'b0 || ser_out1 !== 1'b0 ||
            ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0 || ser_last0 !== 1'b0 ||
            ser_last1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b/%b out=%b/%b valid=%b/%b last=%b/%b done=%b/%b, required all 0",
                     busy0, busy1, ser_out0, ser_out1, ser_valid0, ser_valid1, ser_last0, ser_last1, done0, done1);
        end
        d      = $urandom;
        rd_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_in_reset: busy=%b/%b, required 0/0", busy0, busy1);
        end
        rd_req = 1'b0;
        rset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b/%b valid=%b/%b, required 0", busy0, busy1, ser_valid0, ser_valid1);
        end
    endtask

    task automatic test_basic();
        ser_ready = 1'b1;
        send_word(32'h0000000E, 0, 1'b0, 1'b0);
        n_checks++;
        if (idle_time - cap_time != time'((W+2)*PERIOD - PERIOD/2)) begin
            n_fail++;
            $display("FAIL capture_to_idle: got %0t, required %0d", idle_time - cap_time, (W+2)*PERIOD - PERIOD/2);
        end
        send_word(32'h80000001, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ready_toggle();
        send_word(32'h0000000D, 1, 1'b0, 1'b0);
    endtask

    task automatic test_capture_isolation();
        send_word(32'd8, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            send_word(W'($urandom), 2, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_shift();
        int bad;
        d         = $urandom | 32'h1;
        rd_req    = 1'b1;
        ser_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rset_n = 1'b0;
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0 ||
            done0 !== 1'b0 || done1 !== 1'b0 || ser_out0 !== 1'b0 || ser_last0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_mid_word: busy=%b/%b valid=%b/%b done=%b/%b out=%b last=%b, required all 0",
                     busy0, busy1, ser_valid0, ser_valid1, done0, done1, ser_out0, ser_last0);
        end
        @(negedge clk);
        rset_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy0 | busy1 | ser_valid0 | ser_valid1 | done0 | done1 | ser_last0 | ser_last1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abandoned_word: %0d cycles with activity after reset release, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        time t[3];
        ser_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h00000001, 0, 1'b1, 1'b0);
            t[i] = cap_time;
        end
        rd_req = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (t[i] - t[i-1] != time'((W+2)*PERIOD)) begin
                n_fail++;
                $display("FAIL capture_spacing %0d: got %0t, required %0d", i, t[i] - t[i-1], (W+2)*PERIOD);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_capture_isolation();
        test_random();
        test_reset_mid_shift();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
